// File: rtl/ram_port_arbiter.sv
// Purpose: arbitrates two requesters (cache controller m0, refill/writeback m1) onto one
//          single-port sync-read RAM; round-robin fairness with optional burst lock.
// Latency: grant is combinational in the request cycle; read data returns one cycle later.
// Backpressure: an ungranted requester holds its request until it sees its gnt.
// Ports: clock/rst_n; per requester mX_req/we/lock/addr/wdata in, mX_gnt/rvalid/rdata out;
//        RAM side ram_addr/ram_din/ram_we out, ram_dout in.
module ram_port_arbiter #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, next_state;
    logic   last_ptr, next_ptr;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_ptr <= 1'b1;   // m0 wins the first tie after reset
        end else begin
            state    <= next_state;
            last_ptr <= next_ptr;
        end
    end

    always_comb begin
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        next_state = state;
        next_ptr   = last_ptr;

        // Grants are suppressed while reset is asserted so nothing reaches the RAM.
        if (rst_n) begin
            case (state)
                OWN0: begin
                    if (m0_req) m0_gnt = 1'b1;
                    else        next_state = IDLE;   // owner released without an access
                end
                OWN1: begin
                    if (m1_req) m1_gnt = 1'b1;
                    else        next_state = IDLE;
                end
                default: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last_ptr;
                        m1_gnt = !last_ptr;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
            endcase

            // Lock is only looked at for the requester that actually got the grant.
            if (m0_gnt) begin
                next_state = m0_lock ? OWN0 : IDLE;
                next_ptr   = 1'b0;
            end else if (m1_gnt) begin
                next_state = m1_lock ? OWN1 : IDLE;
                next_ptr   = 1'b1;
            end
        end
    end

    // No grant leaves m0's address on the bus as a harmless read.
    assign ram_addr = m1_gnt ? m1_addr  : m0_addr;
    assign ram_din  = m1_gnt ? m1_wdata : m0_wdata;
    assign ram_we   = (m0_gnt & m0_we) | (m1_gnt & m1_we);

    // One-cycle valid pulse per granted read, aligned with the RAM's registered output.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
        end
    end

    assign m0_rdata = ram_dout;
    assign m1_rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock(clock), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Single-port sync-read RAM, write-first.
    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);

    always @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= ram_din;
        end else begin
            ram_dout      <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
    endtask

    initial begin
        quiet();
        rst_n = 0;
        // Reset gating: a write request must not get through while in reset.
        m0_req = 1; m0_we = 1; m0_addr = 3'd3; m0_wdata = 32'hFFFF_FFFF;
        #2;
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        tick();
        rst_n = 1;

        // 1: lone m0 read of addr 3
        m0_we = 0;
        #2;
        check("t1_m0_gnt", 32'(m0_gnt), 32'd1);
        check("t1_m1_gnt", 32'(m1_gnt), 32'd0);
        check("t1_ram_addr", 32'(ram_addr), 32'd3);
        check("t1_ram_we", 32'(ram_we), 32'd0);
        tick();
        m0_req = 0;
        check("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("t1_m0_rdata", m0_rdata, init_val(3));
        check("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
        tick();
        check("t1_rvalid_pulse", 32'(m0_rvalid), 32'd0);

        // 2: both requesting, no lock -> m0,m1,m0,m1 from reset
        do_reset();
        m0_req = 1; m0_addr = 3'd1;
        m1_req = 1; m1_addr = 3'd5;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t2_m0_gnt_%0d", k), 32'(m0_gnt), 32'((k % 2) == 0));
            check($sformatf("t2_m1_gnt_%0d", k), 32'(m1_gnt), 32'((k % 2) == 1));
            check($sformatf("t2_addr_%0d", k), 32'(ram_addr), (k % 2 == 0) ? 32'd1 : 32'd5);
            if (k > 0) begin
                check($sformatf("t2_m0_rv_%0d", k), 32'(m0_rvalid), 32'((k % 2) == 1));
                check($sformatf("t2_m1_rv_%0d", k), 32'(m1_rvalid), 32'((k % 2) == 0));
                check($sformatf("t2_rdata_%0d", k), ram_dout, (k % 2 == 1) ? init_val(1) : init_val(5));
            end
            tick();
        end
        quiet();
        check("t2_last_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("t2_last_m1_rdata", m1_rdata, init_val(5));

        // Single m0 read of addr 0 so m1 is next in the round-robin.
        m0_req = 1; m0_addr = 3'd0;
        #1;
        check("t3_pre_m0_gnt", 32'(m0_gnt), 32'd1);
        tick();
        m0_req = 0;

        // 3: m1 locked burst of 4 reads while m0 waits on addr 1; m0 lock ignored while waiting
        m0_req = 1; m0_addr = 3'd1; m0_lock = 1;
        m1_req = 1; m1_lock = 1;
        for (int k = 0; k < 4; k++) begin
            m1_addr = 3'(4 + k);
            m1_lock = (k < 3);
            #1;
            check($sformatf("t3_m1_gnt_%0d", k), 32'(m1_gnt), 32'd1);
            check($sformatf("t3_m0_gnt_%0d", k), 32'(m0_gnt), 32'd0);
            check($sformatf("t3_addr_%0d", k), 32'(ram_addr), 32'(4 + k));
            if (k > 0) begin
                check($sformatf("t3_m1_rv_%0d", k), 32'(m1_rvalid), 32'd1);
                check($sformatf("t3_rdata_%0d", k), m1_rdata, init_val(3 + k));
            end
            tick();
        end
        m1_req = 0; m1_lock = 0;
        m0_lock = 0;
        #1;
        check("t3_m0_gnt_c5", 32'(m0_gnt), 32'd1);
        check("t3_m1_rv_last", 32'(m1_rvalid), 32'd1);
        check("t3_m1_rdata_last", m1_rdata, init_val(7));
        tick();
        m0_req = 0;
        check("t3_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("t3_m0_rdata", m0_rdata, init_val(1));
        tick();

        // 4: m0 writes addr 2, m1 reads it back next cycle
        m0_req = 1; m0_we = 1; m0_addr = 3'd2; m0_wdata = 32'hDEAD_BEEF;
        #1;
        check("t4_m0_gnt", 32'(m0_gnt), 32'd1);
        check("t4_ram_we", 32'(ram_we), 32'd1);
        check("t4_ram_din", ram_din, 32'hDEAD_BEEF);
        tick();
        quiet();
        m1_req = 1; m1_addr = 3'd2;
        #1;
        check("t4_no_rvalid_wr", 32'(m0_rvalid), 32'd0);
        check("t4_m1_gnt", 32'(m1_gnt), 32'd1);
        check("t4_rd_we", 32'(ram_we), 32'd0);
        tick();
        m1_req = 0;
        check("t4_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("t4_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        check("t4_m0_rvalid", 32'(m0_rvalid), 32'd0);
        tick();

        // 5: reset during an m1 locked burst
        m1_req = 1; m1_lock = 1; m1_addr = 3'd4;
        #1;
        check("t5_m1_gnt0", 32'(m1_gnt), 32'd1);
        tick();
        m0_req = 1; m0_addr = 3'd6;
        m1_we = 1; m1_addr = 3'd5; m1_wdata = 32'h1234_5678;
        #1;
        check("t5_owner_gnt", 32'(m1_gnt), 32'd1);
        check("t5_m0_blocked", 32'(m0_gnt), 32'd0);
        check("t5_pre_ram_we", 32'(ram_we), 32'd1);
        check("t5_pre_rvalid", 32'(m1_rvalid), 32'd1);
        rst_n = 0;
        #1;
        check("t5_rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check("t5_rst_ram_we", 32'(ram_we), 32'd0);
        check("t5_rst_rvalid", 32'(m1_rvalid), 32'd0);
        tick();
        check("t5_rst_hold_rv", 32'(m1_rvalid), 32'd0);
        rst_n = 1;
        m1_we = 0; m1_lock = 0;
        #1;
        check("t5_tie_m0_gnt", 32'(m0_gnt), 32'd1);
        check("t5_tie_m1_gnt", 32'(m1_gnt), 32'd0);
        tick();
        m0_req = 0;
        check("t5_m0_rdata", m0_rdata, init_val(6));
        check("t5_m1_gnt_next", 32'(m1_gnt), 32'd1);
        tick();
        m1_req = 0;
        check("t5_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("t5_write_dropped", m1_rdata, init_val(5));
        tick();

        // 6: ten idle cycles
        quiet();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t6_we_%0d", k), 32'(ram_we), 32'd0);
            check($sformatf("t6_gnt_%0d", k), 32'({m0_gnt, m1_gnt}), 32'd0);
            check($sformatf("t6_rv_%0d", k), 32'({m0_rvalid, m1_rvalid}), 32'd0);
            tick();
        end
        m0_req = 1; m0_addr = 3'd2;
        tick();
        m0_addr = 3'd3;
        check("t6_mem2", m0_rdata, 32'hDEAD_BEEF);
        tick();
        m0_req = 0;
        check("t6_mem3", m0_rdata, init_val(3));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
